// File: rtl/riscv_test_monitor.sv
// Snoops register-file writes of a RISC-V core under test and reports PASS/FAIL/TIMEOUT.
// Optional event counter on watched-register writes enabled by `define TEST_MONITOR_EVT_CNT_EN.
module riscv_test_monitor #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_WATCH  = 3,
  parameter int WATCH_BASE = 27,
  parameter int DONE_REG   = 26,
  parameter int PASS_REG   = 27,
  parameter int TMO_W      = 16,
  parameter int TMO_LIMIT  = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [NUM_WATCH*DATA_W-1:0]   watch_data,
  output logic [TMO_W-1:0]              cycle_cnt,
  output logic                          busy,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout,
  output logic [15:0]                   evt_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_PASS = 3'd2;
  localparam logic [2:0] S_FAIL = 3'd3;
  localparam logic [2:0] S_TMO  = 3'd4;

  localparam logic [ADDR_W-1:0] DONE_IDX = ADDR_W'(DONE_REG);
  localparam logic [ADDR_W-1:0] PASS_IDX = ADDR_W'(PASS_REG);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_LIMIT - 1);

  logic [2:0]                  r_state;
  logic [2:0]                  w_next;
  logic [TMO_W-1:0]            r_cycle_cnt;
  logic [DATA_W-1:0]           r_shadow;
  logic [NUM_WATCH*DATA_W-1:0] r_watch_data;
  logic                        r_busy;
  logic                        r_pass;
  logic                        r_fail;
  logic                        r_timeout;

  logic w_acc;
  logic w_done;
  logic w_arm;

  assign w_acc  = (r_state == S_RUN) && wr_en && (wr_addr != '0);
  assign w_done = w_acc && (wr_addr == DONE_IDX) && (wr_data != '0);
  // start is ignored while a test is running; any other state rearms.
  assign w_arm  = start && (r_state != S_RUN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_PASS, S_FAIL, S_TMO: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        // A terminating DONE write takes priority over the budget running out.
        if (w_done)
          w_next = (r_shadow == DATA_W'(1)) ? S_PASS : S_FAIL;
        else if (r_cycle_cnt == TMO_LAST)
          w_next = S_TMO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycle_cnt  <= '0;
      r_shadow     <= '0;
      r_watch_data <= '0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next == S_RUN);
      r_pass    <= (w_next == S_PASS);
      r_fail    <= (w_next == S_FAIL);
      r_timeout <= (w_next == S_TMO);
      if (w_arm) begin
        r_cycle_cnt  <= '0;
        r_shadow     <= '0;
        r_watch_data <= '0;
      end else begin
        if (r_state == S_RUN)
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
        if (w_acc && (wr_addr == PASS_IDX))
          r_shadow <= wr_data;
        for (int i = 0; i < NUM_WATCH; i++) begin
          if (w_acc && (wr_addr == ADDR_W'(WATCH_BASE + i)))
            r_watch_data[i*DATA_W +: DATA_W] <= wr_data;
        end
      end
    end
  end

  assign watch_data = r_watch_data;
  assign cycle_cnt  = r_cycle_cnt;
  assign busy       = r_busy;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign timeout    = r_timeout;

`ifdef TEST_MONITOR_EVT_CNT_EN
  localparam logic [ADDR_W-1:0] WIN_LO = ADDR_W'(WATCH_BASE);
  localparam logic [ADDR_W-1:0] WIN_HI = ADDR_W'(WATCH_BASE + NUM_WATCH - 1);

  logic        w_hit;
  logic [15:0] r_evt_cnt;

  assign w_hit = w_acc && (wr_addr >= WIN_LO) && (wr_addr <= WIN_HI);

  always_ff @(posedge clk) begin
    if (rst)
      r_evt_cnt <= '0;
    else if (w_arm)
      r_evt_cnt <= '0;
    else if (w_hit && (r_evt_cnt != 16'hFFFF))
      r_evt_cnt <= r_evt_cnt + 16'd1;
  end

  assign evt_cnt = r_evt_cnt;
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor, built with a 10-cycle budget so timeouts are quick.
module tb_riscv_test_monitor;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NW = 3;
  localparam int TW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NW*DW-1:0] watch_data;
  logic [TW-1:0]    cycle_cnt;
  logic             busy;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [15:0]      evt_cnt;

  int n_total = 0;
  int n_bad   = 0;

`ifdef TEST_MONITOR_EVT_CNT_EN
  localparam logic [15:0] EVT_EXP = 16'd2;
`else
  localparam logic [15:0] EVT_EXP = 16'd0;
`endif

  riscv_test_monitor #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WATCH(NW), .WATCH_BASE(27),
    .DONE_REG(26), .PASS_REG(27), .TMO_W(TW), .TMO_LIMIT(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .watch_data(watch_data), .cycle_cnt(cycle_cnt),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {busy, pass, fail, timeout};
  endfunction

  function automatic logic [DW-1:0] slot(input int i);
    return watch_data[i*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_flags", 64'(flags()), 64'h0);
    chk("rst_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_watch", 64'(|watch_data), 64'd0);
    chk("rst_evt", 64'(evt_cnt), 64'd0);

    // Basic pass: x27=1 then x26=1
    go();
    chk("run_flags", 64'(flags()), 64'h8);
    chk("run_cnt0", 64'(cycle_cnt), 64'd0);
    wr(5'd27, 32'd1);
    chk("run_cnt1", 64'(cycle_cnt), 64'd1);
    wr(5'd26, 32'd1);
    chk("pass_flags", 64'(flags()), 64'h4);
    chk("pass_slot0", 64'(slot(0)), 64'd1);
    chk("pass_cnt", 64'(cycle_cnt), 64'd2);
    tick(2);
    chk("pass_hold", 64'(flags()), 64'h4);
    chk("pass_cnt_frz", 64'(cycle_cnt), 64'd2);

    // Restart from PASS, then fail path
    go();
    chk("rearm_flags", 64'(flags()), 64'h8);
    chk("rearm_cnt", 64'(cycle_cnt), 64'd0);
    chk("rearm_slot0", 64'(slot(0)), 64'd0);
    wr(5'd26, 32'd0);
    chk("done0_nostop", 64'(flags()), 64'h8);
    wr(5'd27, 32'd5);
    chk("slot0_5", 64'(slot(0)), 64'd5);
    wr(5'd26, 32'd1);
    chk("fail_flags", 64'(flags()), 64'h2);
    chk("fail_cnt", 64'(cycle_cnt), 64'd3);
    wr(5'd28, 32'd9);
    chk("fail_wr_ign", 64'(slot(1)), 64'd0);

    // Writes in IDLE ignored; x0 ignored; watched slots mirror
    rst = 1'b1; tick(); rst = 1'b0;
    wr(5'd28, 32'd9);
    chk("idle_wr_ign", 64'(slot(1)), 64'd0);
    chk("idle_flags", 64'(flags()), 64'h0);
    go();
    wr(5'd0, 32'd7);
    wr(5'd28, 32'hDEADBEEF);
    wr(5'd29, 32'd3);
    chk("slot0_x0", 64'(slot(0)), 64'd0);
    chk("slot1_dead", 64'(slot(1)), 64'hDEADBEEF);
    chk("slot2_3", 64'(slot(2)), 64'd3);
    chk("evt_cnt", 64'(evt_cnt), 64'(EVT_EXP));

    // Run out the 10-cycle budget
    tick(6);
    chk("tmo_pre_flags", 64'(flags()), 64'h8);
    chk("tmo_pre_cnt", 64'(cycle_cnt), 64'd9);
    tick();
    chk("tmo_flags", 64'(flags()), 64'h1);
    chk("tmo_cnt", 64'(cycle_cnt), 64'd10);
    tick(3);
    chk("tmo_cnt_frz", 64'(cycle_cnt), 64'd10);
    chk("tmo_slot1_frz", 64'(slot(1)), 64'hDEADBEEF);
    chk("tmo_hold", 64'(flags()), 64'h1);

    // Terminating write on the last budget cycle wins over timeout
    go();
    wr(5'd27, 32'd1);
    tick(8);
    chk("edge_cnt9", 64'(cycle_cnt), 64'd9);
    wr(5'd26, 32'd1);
    chk("edge_pass", 64'(flags()), 64'h4);
    chk("edge_cnt", 64'(cycle_cnt), 64'd10);

    // Reset mid-run aborts, overriding start and wr_en
    go();
    wr(5'd28, 32'd4);
    chk("mid_slot1", 64'(slot(1)), 64'd4);
    rst = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = 5'd28; wr_data = 32'd5;
    tick();
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    chk("abort_flags", 64'(flags()), 64'h0);
    chk("abort_cnt", 64'(cycle_cnt), 64'd0);
    chk("abort_watch", 64'(|watch_data), 64'd0);
    chk("abort_evt", 64'(evt_cnt), 64'd0);

    // start during RUN is ignored
    go();
    tick(2);
    go();
    chk("start_in_run_cnt", 64'(cycle_cnt), 64'd3);
    chk("start_in_run_flags", 64'(flags()), 64'h8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
